// File: rtl/eeprom_word_fetch.sv
// Fetches big-endian multi-byte words from a byte-wide asynchronous EEPROM and
// hands them out as one-cycle VALID pulses, singly or as back-to-back bursts.
module eeprom_word_fetch #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int WORD_BYTES  = 4,
  parameter int WAIT_STATES = 1,
  parameter int BASE        = 0,
  parameter int LEN_W       = 7
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         REQ,
  input  logic [ADDR_W-1:0]            IDX,
  input  logic [LEN_W-1:0]             LEN,
  output logic                         READY,
  output logic                         VALID,
  output logic                         LAST,
  output logic [WORD_BYTES*DATA_W-1:0] WORD,
  output logic [ADDR_W-1:0]            A,
  input  logic [DATA_W-1:0]            IO,
  output logic                         CE,
  output logic                         OE,
  output logic                         WE
);

  localparam int WORD_W = WORD_BYTES * DATA_W;
  localparam int BC_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int WC_W   = 4;

  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(WORD_BYTES - 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_STATES);

  typedef enum logic {
    S_IDLE,
    S_READ
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [WC_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [WORD_W-1:0]   asm_q, asm_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                strobe_n_q, strobe_n_d;

  logic                accept;
  logic                sample;
  logic                word_done;
  logic                more_words;
  logic [ADDR_W-1:0]   start_addr;
  logic [WORD_W-1:0]   assembled;

  assign accept     = REQ && ready_q;
  assign sample     = (state_q == S_READ) && (wait_cnt_q == WAIT_LAST);
  assign word_done  = sample && (byte_cnt_q == LAST_BYTE);
  assign more_words = (remaining_q != LEN_W'(1));
  // Product is formed at 32 bits and truncated, giving the modulo-2^ADDR_W wrap.
  assign start_addr = ADDR_W'(32'(BASE) + 32'(IDX) * 32'(WORD_BYTES));
  assign assembled  = WORD_W'({asm_q, IO});

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of code order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      byte_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      remaining_q <= '0;
      asm_q       <= '0;
      word_q      <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      strobe_n_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      byte_cnt_q  <= byte_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      remaining_q <= remaining_d;
      asm_q       <= asm_d;
      word_q      <= word_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      strobe_n_q  <= strobe_n_d;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default at the top so no
  // path leaves it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_READ;
      S_READ:  if (word_done && !more_words) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d         = a_q;
    byte_cnt_d  = byte_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    remaining_d = remaining_q;
    asm_d       = asm_q;
    word_d      = word_q;
    ready_d     = ready_q;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    strobe_n_d  = strobe_n_q;

    if (state_q == S_IDLE) begin
      if (accept) begin
        a_d         = start_addr;
        remaining_d = (LEN == '0) ? LEN_W'(1) : LEN;
        byte_cnt_d  = '0;
        wait_cnt_d  = '0;
        ready_d     = 1'b0;
        strobe_n_d  = 1'b0;
      end
    end else if (!sample) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_d = '0;
      asm_d      = assembled;
      byte_cnt_d = byte_cnt_q + 1'b1;
      a_d        = a_q + 1'b1;
      if (word_done) begin
        byte_cnt_d = '0;
        word_d     = assembled;
        valid_d    = 1'b1;
        last_d     = !more_words;
        if (more_words) begin
          // Next word begins right after this one's last byte: A just keeps counting.
          remaining_d = remaining_q - 1'b1;
        end else begin
          a_d        = a_q;
          ready_d    = 1'b1;
          strobe_n_d = 1'b1;
        end
      end
    end
  end

  assign READY = ready_q;
  assign VALID = valid_q;
  assign LAST  = last_q;
  assign WORD  = word_q;
  assign A     = a_q;
  assign CE    = strobe_n_q;
  assign OE    = strobe_n_q;
  assign WE    = 1'b1;

endmodule
